// File: rtl/adat_smux_encoder.sv
// ---------------------------------------------------------------------------
// adat_smux_encoder
//
// Serialises one ADAT frame (256 line bits) per 256 bit-rate strobes. Sample
// data is fetched bit by bit from an external circular channel buffer with
// one clock of read latency. That latency is hidden by presenting the
// address two frame positions ahead of the bit being emitted. The first
// returned data bit is held in a local register whenever the strobe is
// idle.
//
// When the producer has not finished a newer frame, the current frame is
// replayed and flagged as an underrun. The replayed frame can optionally be
// muted.
//
// Ports
//   clk_i                  single clock
//   rst_ni                 synchronous active-low reset
//   bit_en_i               ADAT bit-rate strobe, one line bit per high cycle
//   ram_data_i             buffer read data, valid 1 clk after the address
//   last_good_frame_idx_i  newest completely written buffer frame
//   user_bits_i            ADAT user bits, sampled at the frame boundary
//   smux_mode_i            0 = 1x, 1 = SMUX2, 2 = SMUX4, 3 = treated as 1x
//   ram_read_addr_o        {frame, slot[2:0], bit[4:0]}
//   adat_o                 NRZI line output
//   frame_start_o          1-clk pulse with the line update for position 0
//   underrun_o             high for the whole of a replayed frame
// ---------------------------------------------------------------------------
module adat_smux_encoder #(
  parameter int CIRC_BUF_BITS    = 3,
  parameter int SAMPLE_BITS      = 24,
  parameter int MUTE_ON_UNDERRUN = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bit_en_i,
  input  logic                       ram_data_i,
  input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
  input  logic [3:0]                 user_bits_i,
  input  logic [1:0]                 smux_mode_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  output logic                       adat_o,
  output logic                       frame_start_o,
  output logic                       underrun_o
);

  // -------------------------------------------------------------------------
  // Frame position decoding.
  // Positions 16..255 hold 8 channels of 30 bits. Each channel has 6 groups
  // of 5 bits: a '1' sync bit followed by 4 data bits, MSB first.
  // -------------------------------------------------------------------------

  // True when position p carries a sample data bit (not header, not group sync).
  function automatic logic pos_is_data(input logic [7:0] p);
    logic [7:0] d;
    logic [7:0] w;
    logic [7:0] k;
    d = p - 8'd16;
    w = d % 8'd30;
    k = w % 8'd5;
    return (p >= 8'd16) && (k != 8'd0);
  endfunction

  // Sample bit index (0 = MSB) carried at a data position.
  function automatic logic [4:0] pos_bit(input logic [7:0] p);
    logic [7:0] d;
    logic [7:0] w;
    logic [7:0] k;
    d = p - 8'd16;
    w = d % 8'd30;
    k = w % 8'd5;
    return 5'((w / 8'd5) * 8'd4 + k - 8'd1);
  endfunction

  // ADAT channel carried at a position in the channel area.
  function automatic logic [2:0] pos_chan(input logic [7:0] p);
    logic [7:0] d;
    d = p - 8'd16;
    return 3'(d / 8'd30);
  endfunction

  // Buffer slot feeding ADAT channel n under the given S/MUX mode.
  //   SMUX2: slot = (n%2)*4 + n/2
  //   SMUX4: slot = (n%4)*2 + n/4
  function automatic logic [2:0] slot_of(input logic [2:0] n, input logic [1:0] m);
    logic [2:0] s;
    case (m)
      2'd1:    s = {n[0], n[2:1]};
      2'd2:    s = {n[1:0], n[2]};
      default: s = n;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]               pos_q,      pos_d;       // position of the next bit to emit
  logic [CIRC_BUF_BITS-1:0] rd_frame_q, rd_frame_d;  // buffer frame being transmitted
  logic                     underrun_q, underrun_d;
  logic [3:0]               user_q,     user_d;      // user bits latched at the boundary
  logic [1:0]               mode_q,     mode_d;      // S/MUX mode latched at the boundary
  logic [CIRC_BUF_BITS+7:0] addr_q,     addr_d;
  logic                     fresh_q,    fresh_d;     // ram_data_i belongs to pos_q this cycle
  logic                     hold_q,     hold_d;      // held data bit for pos_q
  logic                     adat_q,     adat_d;
  logic                     fs_q,       fs_d;

  // -------------------------------------------------------------------------
  // Current bit and look-ahead address decode
  // -------------------------------------------------------------------------
  logic       cur_is_data;
  logic [4:0] cur_bit;
  logic [7:0] la_pos;
  logic [2:0] la_chan;
  logic [4:0] la_bit;
  logic       ram_bit;
  logic       bit_in_range;
  logic       muted;
  logic       data_bit;
  logic       pre_bit;
  logic       boundary;

  assign cur_is_data = pos_is_data(pos_q);
  assign cur_bit     = pos_bit(pos_q);

  // The address issued when pos_q is consumed belongs to pos_q+2. The
  // address already on the bus (for pos_q+1) returns its data on that same
  // edge. This keeps back-to-back strobes fed with no gap.
  assign la_pos  = pos_q + 8'd2;
  assign la_chan = pos_chan(la_pos);
  assign la_bit  = pos_bit(la_pos);

  // The data for pos_q is on ram_data_i only in the first cycle after the
  // position was entered. After that it comes from the hold register.
  assign ram_bit      = fresh_q ? ram_data_i : hold_q;
  assign bit_in_range = int'(cur_bit) < SAMPLE_BITS;
  assign muted        = (MUTE_ON_UNDERRUN != 0) && underrun_q;
  assign data_bit     = ram_bit && bit_in_range && !muted;

  assign boundary = bit_en_i && (pos_q == 8'd0);

  // Pre-NRZI bit for the current position.
  always_comb begin
    pre_bit = 1'b0;
    if (pos_q < 8'd10) begin
      pre_bit = 1'b0;
    end else if (pos_q == 8'd10) begin
      pre_bit = 1'b1;
    end else if (pos_q < 8'd15) begin
      // position 11 carries user bit 3 ... position 14 carries user bit 0
      pre_bit = user_q[2'(8'd14 - pos_q)];
    end else if (pos_q == 8'd15) begin
      pre_bit = 1'b1;
    end else begin
      pre_bit = cur_is_data ? data_bit : 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pos_d      = pos_q;
    rd_frame_d = rd_frame_q;
    underrun_d = underrun_q;
    user_d     = user_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    adat_d     = adat_q;
    fs_d       = 1'b0;
    fresh_d    = bit_en_i;

    // Capture the returned bit before the address moves on under it.
    if (fresh_q && !bit_en_i) begin
      hold_d = ram_data_i;
    end

    if (bit_en_i) begin
      pos_d  = pos_q + 8'd1;
      adat_d = adat_q ^ pre_bit;
      fs_d   = (pos_q == 8'd0);
      addr_d = {rd_frame_q, slot_of(la_chan, mode_q), la_bit};
    end

    // Emitting position 0 is the frame boundary. The frame choice and the
    // per-frame controls are latched here. Everything that depends on them
    // is needed no earlier than position 11.
    if (boundary) begin
      user_d = user_bits_i;
      mode_d = (smux_mode_i == 2'd3) ? 2'd0 : smux_mode_i;
      if (rd_frame_q != last_good_frame_idx_i) begin
        rd_frame_d = rd_frame_q + 1'b1;
        underrun_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q      <= '0;
      rd_frame_q <= '0;
      underrun_q <= 1'b0;
      user_q     <= '0;
      mode_q     <= '0;
      addr_q     <= '0;
      fresh_q    <= 1'b0;
      hold_q     <= 1'b0;
      adat_q     <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      rd_frame_q <= rd_frame_d;
      underrun_q <= underrun_d;
      user_q     <= user_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      fresh_q    <= fresh_d;
      hold_q     <= hold_d;
      adat_q     <= adat_d;
      fs_q       <= fs_d;
    end
  end

  assign ram_read_addr_o = addr_q;
  assign adat_o          = adat_q;
  assign frame_start_o   = fs_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_adat_smux_encoder.sv
// ---------------------------------------------------------------------------
// tb_adat_smux_encoder
//
// Directed bench for adat_smux_encoder. A behavioural buffer model answers
// read addresses with one clock of latency. Line bits are NRZI-decoded and
// reassembled into channels. Each frame is compared against hand-derived
// expectations.
//
// A second instance with SAMPLE_BITS=16 reads an all-ones buffer. It is used
// to check the truncation of unused low sample bits.
// ---------------------------------------------------------------------------
module tb_adat_smux_encoder;

  localparam int CB = 3;
  localparam int AW = CB + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          bit_en;
  logic          ram_data;
  logic          ram16_data;
  logic [CB-1:0] last_good;
  logic [3:0]    user;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr16;
  logic          adat;
  logic          fs;
  logic          ur;
  logic          adat16;
  logic          fs16;
  logic          ur16;

  adat_smux_encoder #(.CIRC_BUF_BITS(CB), .SAMPLE_BITS(24), .MUTE_ON_UNDERRUN(1)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .bit_en_i              (bit_en),
    .ram_data_i            (ram_data),
    .last_good_frame_idx_i (last_good),
    .user_bits_i           (user),
    .smux_mode_i           (mode),
    .ram_read_addr_o       (addr),
    .adat_o                (adat),
    .frame_start_o         (fs),
    .underrun_o            (ur)
  );

  adat_smux_encoder #(.CIRC_BUF_BITS(CB), .SAMPLE_BITS(16), .MUTE_ON_UNDERRUN(1)) dut16 (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .bit_en_i              (bit_en),
    .ram_data_i            (ram16_data),
    .last_good_frame_idx_i (last_good),
    .user_bits_i           (user),
    .smux_mode_i           (mode),
    .ram_read_addr_o       (addr16),
    .adat_o                (adat16),
    .frame_start_o         (fs16),
    .underrun_o            (ur16)
  );

  // ---------------- buffer model ----------------
  logic [23:0] mem [8][8];

  function automatic logic ram_bit_at(input logic [AW-1:0] a);
    logic [4:0] b;
    b = a[4:0];
    if (b >= 5'd24) return 1'b0;
    return mem[a[AW-1:8]][a[7:5]][5'd23 - b];
  endfunction

  always @(posedge clk) ram_data <= ram_bit_at(addr);
  assign ram16_data = 1'b1;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic          pre_b [256];
  logic          pre16 [256];
  logic          ref_b [256];
  logic          prev;
  logic          prev16;
  int            fs_cnt;
  int            gap_viol;
  logic          fs_at0;
  logic          ur_at0;
  logic          ur_changed;
  logic [CB-1:0] addr_frame;
  logic [23:0]   e_ch [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Emits positions 0..stop_pos-1 with `gap` idle cycles after each strobe.
  // At position chg_pos the per-frame controls are changed mid-frame.
  task automatic run_frame(input int gap, input int chg_pos, input logic [3:0] n_user,
                           input logic [1:0] n_mode, input logic [CB-1:0] n_lg,
                           input int stop_pos);
    fs_cnt     = 0;
    gap_viol   = 0;
    ur_changed = 1'b0;
    for (int p = 0; p < stop_pos; p++) begin
      if (p == chg_pos) begin
        user      = n_user;
        mode      = n_mode;
        last_good = n_lg;
      end
      bit_en = 1'b1;
      @(negedge clk);
      pre_b[p] = adat ^ prev;
      prev     = adat;
      pre16[p] = adat16 ^ prev16;
      prev16   = adat16;
      if (fs) fs_cnt++;
      if (p == 0) begin
        fs_at0 = fs;
        ur_at0 = ur;
      end else if (ur !== ur_at0) begin
        ur_changed = 1'b1;
      end
      if (p == 100) addr_frame = addr[AW-1:8];
      if (gap > 0) begin
        bit_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (adat !== prev || fs) gap_viol++;
        end
      end
    end
  endtask

  // ---------------- frame decoding ----------------
  function automatic logic get_pre(input int p, input bit sel16);
    return sel16 ? pre16[p] : pre_b[p];
  endfunction

  function automatic logic [15:0] hdr_of(input bit sel16);
    logic [15:0] h;
    for (int p = 0; p < 16; p++) h[15-p] = get_pre(p, sel16);
    return h;
  endfunction

  function automatic int sync_ones(input bit sel16);
    int c;
    c = 0;
    for (int n = 0; n < 8; n++)
      for (int g = 0; g < 6; g++)
        if (get_pre(16 + 30*n + 5*g, sel16)) c++;
    return c;
  endfunction

  function automatic logic [23:0] chan_of(input int n, input bit sel16);
    logic [23:0] v;
    v = '0;
    for (int g = 0; g < 6; g++)
      for (int j = 0; j < 4; j++)
        v[23 - (4*g + j)] = get_pre(16 + 30*n + 5*g + 1 + j, sel16);
    return v;
  endfunction

  task automatic check_frame(input string tag, input bit sel16, input logic [15:0] e_hdr,
                             input logic [23:0] e [8]);
    check({tag, "_hdr"}, 32'(hdr_of(sel16)), 32'(e_hdr));
    check({tag, "_sync"}, sync_ones(sel16), 48);
    for (int n = 0; n < 8; n++)
      check($sformatf("%s_ch%0d", tag, n), 32'(chan_of(n, sel16)), 32'(e[n]));
  endtask

  task automatic check_ctrl(input string tag, input logic e_ur, input logic [CB-1:0] e_frame);
    check({tag, "_fs_at0"}, 32'(fs_at0), 32'd1);
    check({tag, "_fs_cnt"}, fs_cnt, 1);
    check({tag, "_underrun"}, 32'(ur_at0), 32'(e_ur));
    check({tag, "_underrun_steady"}, 32'(ur_changed), 32'd0);
    check({tag, "_rd_frame"}, 32'(addr_frame), 32'(e_frame));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adat"}, 32'(adat), 32'd0);
    check({tag, "_fs"}, 32'(fs), 32'd0);
    check({tag, "_ur"}, 32'(ur), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int diffs;
    for (int f = 0; f < 8; f++)
      for (int s = 0; s < 8; s++)
        mem[f][s] = 24'h3C0000 | (24'(f) << 8) | 24'(s);
    for (int s = 0; s < 8; s++) begin
      mem[1][s] = 24'hA50000 | 24'(s);
      mem[3][s] = 24'(s);
      mem[4][s] = 24'(s);
    end

    rst_n     = 1'b0;
    bit_en    = 1'b0;
    user      = 4'b1010;
    mode      = 2'd0;
    last_good = 3'd1;
    prev      = 1'b0;
    prev16    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_adat16", 32'(adat16), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1, mode 0, strobe every clock.
    run_frame(0, -1, 4'b1010, 2'd0, 3'd1, 256);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'hA50000 | 24'(k);
    check_frame("f1", 1'b0, 16'h0035, e_ch);
    check_ctrl("f1", 1'b0, 3'd1);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'hFFFF00;
    check_frame("f1_sb16", 1'b1, 16'h0035, e_ch);
    for (int p = 0; p < 256; p++) ref_b[p] = pre_b[p];

    // last_good still 1: frame 1 is replayed muted. Controls changed before
    // the user-bit positions must not show up until the next frame.
    run_frame(0, 5, 4'b0101, 2'd0, 3'd2, 256);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'h000000;
    check_frame("under1", 1'b0, 16'h0035, e_ch);
    check_ctrl("under1", 1'b1, 3'd1);

    // Frame 2. The SMUX2 request made mid-frame waits for the next frame.
    run_frame(0, 5, 4'b0101, 2'd1, 3'd3, 256);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'h3C0200 | 24'(k);
    check_frame("f2", 1'b0, 16'h002B, e_ch);
    check_ctrl("f2", 1'b0, 3'd2);

    // Frame 3 in SMUX2: channel order 0,4,1,5,2,6,3,7.
    run_frame(0, 5, 4'b0101, 2'd2, 3'd4, 256);
    e_ch = '{24'd0, 24'd4, 24'd1, 24'd5, 24'd2, 24'd6, 24'd3, 24'd7};
    check_frame("smux2", 1'b0, 16'h002B, e_ch);
    check_ctrl("smux2", 1'b0, 3'd3);

    // Frame 4 in SMUX4: channel order 0,2,4,6,1,3,5,7.
    run_frame(0, 5, 4'b0101, 2'd0, 3'd7, 256);
    e_ch = '{24'd0, 24'd2, 24'd4, 24'd6, 24'd1, 24'd3, 24'd5, 24'd7};
    check_frame("smux4", 1'b0, 16'h002B, e_ch);
    check_ctrl("smux4", 1'b0, 3'd4);

    // Frames 5 and 6, then 7 with last_good moved to 0 for the wrap.
    run_frame(0, -1, 4'b0101, 2'd0, 3'd7, 256);
    check_ctrl("f5", 1'b0, 3'd5);
    run_frame(0, -1, 4'b0101, 2'd0, 3'd7, 256);
    check_ctrl("f6", 1'b0, 3'd6);
    run_frame(0, 5, 4'b0101, 2'd0, 3'd0, 256);
    check_ctrl("f7", 1'b0, 3'd7);

    // 7 -> 0 wrap.
    run_frame(0, -1, 4'b0101, 2'd0, 3'd0, 256);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'h3C0000 | 24'(k);
    check_frame("wrap0", 1'b0, 16'h002B, e_ch);
    check_ctrl("wrap0", 1'b0, 3'd0);

    // last_good held at 0: frame 0 replayed muted.
    run_frame(0, -1, 4'b0101, 2'd0, 3'd0, 256);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'h000000;
    check_frame("under0", 1'b0, 16'h002B, e_ch);
    check_ctrl("under0", 1'b1, 3'd0);

    // Another replay, aborted by a one-clock reset at position 100.
    run_frame(0, 5, 4'b0101, 2'd0, 3'd1, 100);
    check("pre_abort_ur", 32'(ur), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n  = 1'b1;
    bit_en = 1'b0;
    prev   = 1'b0;
    prev16 = 1'b0;
    @(negedge clk);
    check("abort_idle_adat", 32'(adat), 32'd0);
    run_frame(0, -1, 4'b0101, 2'd0, 3'd1, 256);
    for (int k = 0; k < 8; k++) e_ch[k] = 24'hA50000 | 24'(k);
    check_frame("restart", 1'b0, 16'h002B, e_ch);
    check_ctrl("restart", 1'b0, 3'd1);

    // Strobe 1 clock in 4: the same line sequence as the first frame.
    bit_en    = 1'b0;
    user      = 4'b1010;
    mode      = 2'd0;
    last_good = 3'd1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    prev   = 1'b0;
    prev16 = 1'b0;
    @(negedge clk);
    run_frame(3, -1, 4'b1010, 2'd0, 3'd1, 256);
    bit_en = 1'b0;
    diffs  = 0;
    for (int p = 0; p < 256; p++) if (pre_b[p] !== ref_b[p]) diffs++;
    check("gap_bits_diff", diffs, 0);
    check("gap_idle_changes", gap_viol, 0);
    check("gap_fs_cnt", fs_cnt, 1);
    check("gap_fs_at0", 32'(fs_at0), 32'd1);
    check("gap_rd_frame", 32'(addr_frame), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adat_smux_encoder.md
ADAT_SMUX_ENCODER -- requirements
Module: adat_smux_encoder

Interface
REQ-001 SHALL have parameter CIRC_BUF_BITS, default 3, meaning log2 of the frame count in the circular channel buffer.
REQ-002 SHALL have parameter SAMPLE_BITS, default 24, range 16..24, meaning valid MSB-aligned bits per sample; the remaining LSBs of each 24-bit slot are transmitted as 0.
REQ-003 SHALL have parameter MUTE_ON_UNDERRUN, default 1, meaning data bits are forced to 0 during an underrun frame.
REQ-004 SHALL have ports:
- clk_i, input, 1: single clock.
- rst_ni, input, 1: synchronous, active-low reset.
- bit_en_i, input, 1: ADAT bit-rate strobe; one line bit is emitted per high cycle.
- ram_data_i, input, 1: channel buffer read data, valid 1 clk after the address.
- last_good_frame_idx_i, input, CIRC_BUF_BITS: newest fully written frame.
- user_bits_i, input, 4: ADAT user bits.
- smux_mode_i, input, 2: 0 = 1x, 1 = SMUX2, 2 = SMUX4, 3 = reserved (treated as 0).
- ram_read_addr_o, output, CIRC_BUF_BITS+8: {frame, slot[2:0], bit[4:0]}.
- adat_o, output, 1: NRZI line output.
- frame_start_o, output, 1: one-clk pulse when bit 0 of a frame is emitted.
- underrun_o, output, 1: high for the whole frame being replayed.

Function
REQ-005 SHALL run a 256-position frame counter that advances by 1 per bit_en_i high cycle and wraps 255->0; bit_en_i low holds all state.
REQ-006 Pre-NRZI frame SHALL be: positions 0-9 = 0; 10 = 1; 11-14 = user_bits_i[3], [2], [1], [0]; 15 = 1; 16-255 = 8 channels x 6 groups, each group being '1' followed by 4 data bits, MSB first.
REQ-007 NRZI SHALL toggle adat_o when the pre-NRZI bit is 1 and hold adat_o when it is 0; adat_o SHALL update on the clk after the bit_en_i cycle.
REQ-008 ADAT channel n bit b (b = 0 is the MSB, b < 24) SHALL be read from address {rd_frame, slot(n), b[4:0]}; bits with b >= SAMPLE_BITS SHALL transmit 0 without depending on ram_data_i.
REQ-009 slot(n) SHALL be: mode 0: n; SMUX2: (n%2)*4 + n/2; SMUX4: (n%4)*2 + n/4.
REQ-010 The 1-clk RAM latency SHALL be hidden by prefetch, so bit_en_i may be high every cycle with no gap in adat_o.
REQ-011 ram_read_addr_o SHALL be driven to the needed address at least 1 clk before its data is consumed.
REQ-012 At frame boundary (position 255 -> 0), if rd_frame != last_good_frame_idx_i, the block SHALL set rd_frame = rd_frame+1 mod 2^CIRC_BUF_BITS and clear underrun_o.
REQ-013 At frame boundary, if rd_frame == last_good_frame_idx_i, the block SHALL keep rd_frame (replaying that frame) and set underrun_o=1 for the frame.
REQ-014 If MUTE_ON_UNDERRUN=1, all 192 data bits of an underrun frame SHALL be 0 while framing '1' bits are still sent.
REQ-015 user_bits_i, smux_mode_i and last_good_frame_idx_i SHALL be sampled only at the frame boundary; mid-frame changes SHALL take effect at the next frame.
REQ-016 frame_start_o SHALL pulse for exactly 1 clk per frame, coincident with the adat_o update for position 0.

Reset
REQ-017 While rst_ni=0 at a clk edge, the block SHALL set adat_o=0, frame_start_o=0, underrun_o=0, frame counter=0, rd_frame=0, ram_read_addr_o=0 and NRZI state=0.
REQ-018 After reset release, the first emitted bit SHALL be position 0 of a frame, and the first boundary decision SHALL follow REQ-012/013.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately, with no partial output after release.

Verification
REQ-020 Mode 0, bit_en_i always high, RAM slot k of frame 1 = 24'hA5000k, last_good=1 -> decoded frame carries channels k = 0xA5000k, user bits as driven, frames back-to-back every 256 clk.
REQ-021 bit_en_i high 1 clk in 4 -> identical bit sequence to REQ-020, with each adat_o change exactly 1 clk after a strobe.
REQ-022 SMUX2 with RAM slots 0..7 = 0..7 -> ADAT channel order 0,4,1,5,2,6,3,7; SMUX4 -> 0,2,4,6,1,3,5,7.
REQ-023 last_good held at 2 after frame 2 -> underrun_o=1, frame 2 replayed with all-zero data (MUTE_ON_UNDERRUN=1); raising last_good to 3 -> frame 3 next, underrun_o=0; also check 7->0 wrap with CIRC_BUF_BITS=3.
REQ-024 SAMPLE_BITS=16, RAM all ones -> each channel = 24'hFFFF00.
REQ-025 rst_ni low at position 100 for 1 clk -> all outputs 0; the next frame begins with 10 non-toggling bits then a toggle, read from frame 0 or 1 per REQ-012/013.
